// File: rtl/test_result_collector.sv
`timescale 1ns/1ps
// test_result_collector
//   Pops per-page test-result bytes {1'b0, pass, page[5:0]} from a UART RX FIFO,
//   keeps a pass/seen bitmap per page, pass/fail counters and sticky protocol
//   error flags, and flags completion after NUM_PAGES in-range results.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   clear               synchronous clear of all results (back to IDLE)
//   uart_empty          RX FIFO empty flag
//   uart_rx_data        RX FIFO read data, valid the cycle after uart_read
//   uart_read           one-cycle FIFO pop strobe
//   pass_map, seen_map  per-page last pass bit / page-received bit
//   pass_count          in-range results with pass=1
//   fail_count          in-range results with pass=0
//   last_page           page field of the most recently decoded byte
//   done, all_pass      completion and clean-completion status
//   err_format          sticky: byte with bit7 set
//   err_sequence        sticky: page differed from the expected page
//   err_range           sticky: page >= NUM_PAGES
//   err_overrun         sticky: byte received after done
module test_result_collector #(
    parameter int unsigned NUM_PAGES = 17,
    parameter int unsigned PAGE_W    = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 uart_empty,
    input  logic [7:0]           uart_rx_data,
    output logic                 uart_read,
    output logic [NUM_PAGES-1:0] pass_map,
    output logic [NUM_PAGES-1:0] seen_map,
    output logic [6:0]           pass_count,
    output logic [6:0]           fail_count,
    output logic [PAGE_W-1:0]    last_page,
    output logic                 done,
    output logic                 all_pass,
    output logic                 err_format,
    output logic                 err_sequence,
    output logic                 err_range,
    output logic                 err_overrun
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCapture = 2'd1;
    localparam logic [1:0] StDecode  = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    localparam logic [6:0] NumPagesC = 7'(NUM_PAGES);

    logic [1:0]           state_q, state_d;
    logic [7:0]           byte_q, byte_d;
    logic [NUM_PAGES-1:0] pass_map_q, pass_map_d;
    logic [NUM_PAGES-1:0] seen_map_q, seen_map_d;
    logic [6:0]           pass_count_q, pass_count_d;
    logic [6:0]           fail_count_q, fail_count_d;
    logic [PAGE_W-1:0]    last_page_q, last_page_d;
    logic [6:0]           expected_q, expected_d;
    logic                 done_q, done_d;
    logic                 err_format_q, err_format_d;
    logic                 err_sequence_q, err_sequence_d;
    logic                 err_range_q, err_range_d;
    logic                 err_overrun_q, err_overrun_d;

    logic [PAGE_W-1:0]    page;
    logic [6:0]           page_ext;
    logic [6:0]           total_next;
    logic                 any_error;

    assign page       = byte_q[PAGE_W-1:0];
    assign page_ext   = 7'(page);
    assign total_next = pass_count_q + fail_count_q + 7'd1;
    assign any_error  = err_format_q | err_sequence_q | err_range_q | err_overrun_q;

    // Pops happen from IDLE (normal) and DONE (drain and discard); gating with
    // reset_n drops the strobe as soon as reset is applied.
    assign uart_read = reset_n & ~clear & ~uart_empty &
                       ((state_q == StIdle) | (state_q == StDone));

    always_comb begin
        state_d        = state_q;
        byte_d         = byte_q;
        pass_map_d     = pass_map_q;
        seen_map_d     = seen_map_q;
        pass_count_d   = pass_count_q;
        fail_count_d   = fail_count_q;
        last_page_d    = last_page_q;
        expected_d     = expected_q;
        done_d         = done_q;
        err_format_d   = err_format_q;
        err_sequence_d = err_sequence_q;
        err_range_d    = err_range_q;
        err_overrun_d  = err_overrun_q;

        unique case (state_q)
            StIdle: begin
                if (!uart_empty) state_d = StCapture;
            end
            StCapture: begin
                byte_d  = uart_rx_data;
                state_d = StDecode;
            end
            StDecode: begin
                if (done_q) begin
                    // Results are frozen once complete; anything extra is discarded.
                    err_overrun_d = 1'b1;
                    state_d       = StDone;
                end else if (byte_q[7]) begin
                    err_format_d = 1'b1;
                    state_d      = StIdle;
                end else if (page_ext >= NumPagesC) begin
                    err_range_d = 1'b1;
                    last_page_d = page;
                    state_d     = StIdle;
                end else begin
                    for (int unsigned p = 0; p < NUM_PAGES; p++) begin
                        if (page_ext == 7'(p)) begin
                            pass_map_d[p] = byte_q[6];
                            seen_map_d[p] = 1'b1;
                        end
                    end
                    last_page_d = page;
                    if (byte_q[6]) pass_count_d = pass_count_q + 7'd1;
                    else           fail_count_d = fail_count_q + 7'd1;
                    if (page_ext != expected_q) err_sequence_d = 1'b1;
                    // Resynchronise to the page actually received.
                    expected_d = page_ext + 7'd1;
                    if (total_next == NumPagesC) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDone: begin
                if (!uart_empty) state_d = StCapture;
            end
            default: state_d = StIdle;
        endcase

        if (clear) begin
            state_d        = StIdle;
            byte_d         = '0;
            pass_map_d     = '0;
            seen_map_d     = '0;
            pass_count_d   = '0;
            fail_count_d   = '0;
            last_page_d    = '0;
            expected_d     = '0;
            done_d         = 1'b0;
            err_format_d   = 1'b0;
            err_sequence_d = 1'b0;
            err_range_d    = 1'b0;
            err_overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            byte_q         <= '0;
            pass_map_q     <= '0;
            seen_map_q     <= '0;
            pass_count_q   <= '0;
            fail_count_q   <= '0;
            last_page_q    <= '0;
            expected_q     <= '0;
            done_q         <= 1'b0;
            err_format_q   <= 1'b0;
            err_sequence_q <= 1'b0;
            err_range_q    <= 1'b0;
            err_overrun_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_q         <= byte_d;
            pass_map_q     <= pass_map_d;
            seen_map_q     <= seen_map_d;
            pass_count_q   <= pass_count_d;
            fail_count_q   <= fail_count_d;
            last_page_q    <= last_page_d;
            expected_q     <= expected_d;
            done_q         <= done_d;
            err_format_q   <= err_format_d;
            err_sequence_q <= err_sequence_d;
            err_range_q    <= err_range_d;
            err_overrun_q  <= err_overrun_d;
        end
    end

    assign pass_map     = pass_map_q;
    assign seen_map     = seen_map_q;
    assign pass_count   = pass_count_q;
    assign fail_count   = fail_count_q;
    assign last_page    = last_page_q;
    assign done         = done_q;
    assign all_pass     = done_q & (pass_count_q == NumPagesC) & ~any_error;
    assign err_format   = err_format_q;
    assign err_sequence = err_sequence_q;
    assign err_range    = err_range_q;
    assign err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_test_result_collector.sv
`timescale 1ns/1ps
// Bench for test_result_collector: a queue-based RX FIFO, a transaction-level
// model of decoded results, a per-cycle compare and directed plus random runs.
module tb_test_result_collector;

    localparam int N = 17;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clear = 1'b0;
    logic         uart_empty = 1'b1;
    logic [7:0]   uart_rx_data = 8'h00;
    logic         uart_read;
    logic [N-1:0] pass_map;
    logic [N-1:0] seen_map;
    logic [6:0]   pass_count;
    logic [6:0]   fail_count;
    logic [5:0]   last_page;
    logic         done;
    logic         all_pass;
    logic         err_format;
    logic         err_sequence;
    logic         err_range;
    logic         err_overrun;

    test_result_collector #(.NUM_PAGES(N), .PAGE_W(6)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .uart_empty   (uart_empty),
        .uart_rx_data (uart_rx_data),
        .uart_read    (uart_read),
        .pass_map     (pass_map),
        .seen_map     (seen_map),
        .pass_count   (pass_count),
        .fail_count   (fail_count),
        .last_page    (last_page),
        .done         (done),
        .all_pass     (all_pass),
        .err_format   (err_format),
        .err_sequence (err_sequence),
        .err_range    (err_range),
        .err_overrun  (err_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RX FIFO ----------------
    logic [7:0] push_q[$];
    logic [7:0] fifo[$];
    logic [7:0] fifo_tmp;
    int         dut_pops = 0;
    int         cyc = 0;
    int         last_pop_cyc = -100;

    always @(posedge clk) begin
        if (uart_read) begin
            dut_pops++;
            chk("pop_when_empty", uart_empty, 1'b0);
            chk("pop_spacing", (cyc - last_pop_cyc) >= 3, 1'b1);
            last_pop_cyc = cyc;
            if (fifo.size() > 0) begin
                fifo_tmp = fifo.pop_front();
                uart_rx_data <= fifo_tmp;
            end
        end
        // A clear or reset restarts the byte cadence.
        if (!reset_n || clear) last_pop_cyc = -100;
        while (push_q.size() > 0) fifo.push_back(push_q.pop_front());
        uart_empty <= (fifo.size() == 0);
        cyc++;
    end

    // ---------------- reference model ----------------
    // res_q holds every accepted in-range result since the last clear/reset;
    // all map/counter/sequence expectations are derived from it on demand.
    logic [7:0] res_q[$];
    bit         m_fmt, m_rng, m_ovr;
    logic [5:0] m_last;
    int         stage = 0;   // 0: ready to pop, 1: byte popped, 2: byte held
    logic [7:0] pend;

    function automatic void model_clear();
        res_q.delete();
        m_fmt  = 1'b0;
        m_rng  = 1'b0;
        m_ovr  = 1'b0;
        m_last = '0;
        stage  = 0;
    endfunction

    function automatic void model_apply(input logic [7:0] b);
        if (res_q.size() == N) m_ovr = 1'b1;
        else if (b[7]) m_fmt = 1'b1;
        else if (int'(b[5:0]) >= N) begin
            m_rng  = 1'b1;
            m_last = b[5:0];
        end else begin
            res_q.push_back(b);
            m_last = b[5:0];
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || clear) model_clear();
        else if (stage == 2) begin
            model_apply(pend);
            stage = 0;
        end else if (stage == 1) begin
            pend  = uart_rx_data;
            stage = 2;
        end else if (!uart_empty) begin
            stage = 1;
        end
    end

    task automatic compare_all();
        logic [N-1:0] ep;
        logic [N-1:0] es;
        int pc;
        int fc;
        bit seq;
        bit edone;
        bit anyerr;
        ep  = '0;
        es  = '0;
        pc  = 0;
        seq = 1'b0;
        for (int i = 0; i < res_q.size(); i++) begin
            int pg;
            int want;
            pg   = int'(res_q[i][5:0]);
            want = (i == 0) ? 0 : int'(res_q[i-1][5:0]) + 1;
            if (pg != want) seq = 1'b1;
            ep[pg] = res_q[i][6];
            es[pg] = 1'b1;
            if (res_q[i][6]) pc++;
        end
        fc     = res_q.size() - pc;
        edone  = (res_q.size() == N);
        anyerr = m_fmt | m_rng | m_ovr | seq;
        chk("uart_read", uart_read, reset_n && !clear && !uart_empty && stage == 0);
        chk("pass_map", pass_map, ep);
        chk("seen_map", seen_map, es);
        chk("pass_count", pass_count, pc);
        chk("fail_count", fail_count, fc);
        chk("last_page", last_page, m_last);
        chk("done", done, edone);
        chk("all_pass", all_pass, edone && pc == N && !anyerr);
        chk("err_format", err_format, m_fmt);
        chk("err_sequence", err_sequence, seq);
        chk("err_range", err_range, m_rng);
        chk("err_overrun", err_overrun, m_ovr);
    endtask

    always @(posedge clk) begin
        #1;
        if (cmp_en) compare_all();
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [7:0] b);
        push_q.push_back(b);
    endtask

    task automatic push_run(input int pass_fail_page);
        for (int p = 0; p < N; p++) push({1'b0, (p != pass_fail_page), 6'(p)});
    endtask

    task automatic do_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((push_q.size() != 0 || fifo.size() != 0 || uart_empty !== 1'b1 || stage != 0)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain_in_time", n < 3000, 1'b1);
    endtask

    function automatic logic [3:0] errs();
        return {err_format, err_sequence, err_range, err_overrun};
    endfunction

    task automatic random_run(input int nbytes, input bit mid_clear);
        int nextpg;
        int clear_at;
        nextpg   = 0;
        clear_at = mid_clear ? int'($urandom_range(5, nbytes - 5)) : -1;
        do_clear();
        for (int i = 0; i < nbytes; i++) begin
            int r;
            logic [7:0] b;
            r = int'($urandom_range(0, 99));
            if (r < 75) begin
                b      = {1'b0, 1'($urandom_range(0, 1)), 6'(nextpg)};
                nextpg = (nextpg + 1) % N;
            end else if (r < 85) begin
                b = {1'b0, 7'($urandom)};
            end else if (r < 93) begin
                b = 8'($urandom) | 8'h80;
            end else begin
                b = {1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, N - 1))};
            end
            push(b);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            if (i == clear_at) do_clear();
        end
        wait_drain();
    endtask

    // ---------------- test sequence ----------------
    int base;

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_pass_count", pass_count, 7'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_uart_read", uart_read, 1'b0);
        chk("rst_maps", {pass_map, seen_map}, '0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(negedge clk);

        // 1: clean run of 17 passing pages.
        base = dut_pops;
        push_run(-1);
        wait_drain();
        chk("t1_done", done, 1'b1);
        chk("t1_pass_count", pass_count, 7'd17);
        chk("t1_fail_count", fail_count, 7'd0);
        chk("t1_pass_map", pass_map, 17'h1FFFF);
        chk("t1_all_pass", all_pass, 1'b1);
        chk("t1_errors", errs(), 4'h0);
        chk("t1_pops", dut_pops - base, 17);

        // 2: page 5 reported as a fail.
        do_clear();
        push_run(5);
        wait_drain();
        chk("t2_fail_count", fail_count, 7'd1);
        chk("t2_pass_count", pass_count, 7'd16);
        chk("t2_pass_map", pass_map, 17'h1FFDF);
        chk("t2_all_pass", all_pass, 1'b0);
        chk("t2_err_sequence", err_sequence, 1'b0);

        // 3: out-of-order pages.
        do_clear();
        push(8'h40);
        push(8'h42);
        push(8'h41);
        for (int p = 3; p < N; p++) push(8'h40 | 8'(p));
        wait_drain();
        chk("t3_err_sequence", err_sequence, 1'b1);
        chk("t3_seen_map", seen_map, 17'h1FFFF);
        chk("t3_done", done, 1'b1);

        // 4: format and range errors, then a full run.
        do_clear();
        push(8'hC3);
        push(8'h51);
        wait_drain();
        chk("t4_err_format", err_format, 1'b1);
        chk("t4_err_range", err_range, 1'b1);
        chk("t4_last_page", last_page, 6'd17);
        chk("t4_counts", {pass_count, fail_count}, 14'd0);
        chk("t4_done", done, 1'b0);
        push_run(-1);
        wait_drain();
        chk("t4_done_after", done, 1'b1);
        chk("t4_all_pass", all_pass, 1'b0);

        // 5: overrun after done, then clear and a clean run.
        push(8'h51);
        wait_drain();
        chk("t5_err_overrun", err_overrun, 1'b1);
        chk("t5_pass_count", pass_count, 7'd17);
        do_clear();
        chk("t5_cleared", {pass_map, seen_map, pass_count, fail_count, done, errs()}, '0);
        push_run(-1);
        wait_drain();
        chk("t5_all_pass", all_pass, 1'b1);

        // 6: reset while the 8th byte is being captured.
        do_clear();
        base = dut_pops;
        push_run(-1);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (dut_pops - base < 8 && n < 2000);
        chk("t6_reached_8th", n < 2000, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_counts", {pass_count, fail_count}, 14'd0);
        chk("t6_rst_maps", {pass_map, seen_map}, '0);
        chk("t6_rst_flags", {done, all_pass, errs(), last_page}, '0);
        @(negedge clk);
        chk("t6_no_read_in_reset", {uart_empty, uart_read}, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        wait_drain();
        chk("t6_pass_count", pass_count, 7'd9);
        chk("t6_seen_map", seen_map, 17'h1FF00);
        chk("t6_err_sequence", err_sequence, 1'b1);
        chk("t6_done", done, 1'b0);

        // Randomised runs.
        for (int r = 0; r < 6; r++) random_run(40, r % 3 == 2);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/test_result_collector.md
Name: test_result_collector

Overview:
- Reads per-page test-result bytes from a UART RX byte FIFO and decodes them.
- Each byte has the format {1'b0, pass, page[5:0]}.
- Keeps a per-page pass bitmap, pass/fail counters and protocol error flags, and signals completion after NUM_PAGES in-range results.
- Sits at the receiving end of the tester's result link, e.g. on a monitor board or in loopback, driving LEDs and status registers.

Parameters:
- NUM_PAGES, 17, number of result pages expected; legal range 1..64.
- PAGE_W, 6, width of the page field in the result byte; fixed at 6.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear of all results and return to IDLE; has priority over everything except reset_n
- uart_empty  in  1  RX FIFO empty flag
- uart_rx_data  in  8  RX FIFO read data; valid in the cycle after uart_read
- uart_read  out  1  one-cycle FIFO pop strobe
- pass_map  out  NUM_PAGES  bit p = pass bit of the last result for page p
- seen_map  out  NUM_PAGES  bit p = page p has been received at least once
- pass_count  out  7  number of in-range results with pass=1
- fail_count  out  7  number of in-range results with pass=0
- last_page  out  6  page field of the most recently decoded byte
- done  out  1  NUM_PAGES in-range results received
- all_pass  out  1  done & (pass_count==NUM_PAGES) & ~any_error
- err_format  out  1  sticky: a byte had bit7=1
- err_sequence  out  1  sticky: page != expected page
- err_range  out  1  sticky: page >= NUM_PAGES
- err_overrun  out  1  sticky: byte received while done

Behaviour:
- Reset (async on reset_n low) and clear both set every output, counter and flag to 0, expected_page=0 and state=IDLE.
- The FSM has four states: IDLE, CAPTURE, DECODE, DONE.
- IDLE: if !uart_empty, assert uart_read for exactly one cycle and go to CAPTURE. Otherwise stay.
- CAPTURE: uart_read=0; latch uart_rx_data into byte_q; go to DECODE.
- DECODE, format check: if byte_q[7]=1, set err_format, change no other state, and go to IDLE.
- DECODE, range check: if page=byte_q[5:0] >= NUM_PAGES, set err_range, update last_page, and go to IDLE. The map and counters are unchanged.
- DECODE, in-range byte:
  - pass_map[page] <= byte_q[6]; seen_map[page] <= 1; last_page <= page.
  - Increment pass_count if byte_q[6]=1, else increment fail_count.
  - If page != expected_page, set err_sequence.
  - expected_page <= page+1, i.e. resynchronise to the received page.
  - If pass_count+fail_count after the update equals NUM_PAGES, go to DONE; else go to IDLE.
- Duplicate page: the map bit is overwritten, counters still increment, and err_sequence is set.
- DONE: done=1.
  - Any byte still in the FIFO is popped (same IDLE/CAPTURE pop timing) and discarded, and err_overrun is set.
  - Counters and maps are frozen.
  - Only clear or reset leaves DONE.
- Throughput: at most one byte per 3 cycles. uart_read is never asserted in CAPTURE or DECODE, and never when uart_empty=1.
- all_pass is combinational from registered state. any_error = OR of the four error flags.
- Counters are 7 bits wide and cannot overflow, because NUM_PAGES ≤ 64 stops counting at DONE.
- uart_empty rising between pop and capture has no effect: data is taken in CAPTURE regardless.
- clear asserted in any state: next cycle state=IDLE with everything zeroed, and any in-flight byte is dropped.
- reset_n deasserted mid-operation (i.e. reset applied): immediate zeroing; uart_read goes low asynchronously.

Test Plan:
1. NUM_PAGES=17; feed 0x40..0x50 (pages 0..16, all pass) → done=1, pass_count=17, fail_count=0, pass_map=17'h1FFFF, all_pass=1, no errors, and exactly 17 uart_read pulses spaced ≥3 cycles.
2. Feed pages 0..16 with page 5 sent as 0x05 (fail) → fail_count=1, pass_count=16, pass_map[5]=0, all_pass=0, err_sequence=0.
3. Feed 0x40, 0x42, 0x41, then the rest → err_sequence=1, all seen bits set, done after the 17th in-range byte.
4. Feed 0xC3, then 0x51 (page 17) → err_format=1, err_range=1, last_page=17, counters 0, not done. Then feed 17 valid bytes → done=1, all_pass=0.
5. After done, push 0x51 → popped and discarded, err_overrun=1, counters unchanged. Pulse clear → all outputs 0, and a new run completes cleanly.
6. Assert reset_n low for 2 cycles during CAPTURE of the 8th byte → all outputs 0 immediately. After release, the FIFO byte is re-read normally and uart_read never fires while uart_empty=1.
